// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: decoded operand/producer fields in, stall/MDU status out.
// The master side (decode) drives the D fields; the scoreboard is the slave.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int CW = 32
);
  logic          d_valid;
  logic          d_use_rs;
  logic          d_use_rt;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [AW-1:0] d_a3;
  logic [TW-1:0] d_tnew;
  logic          d_mdu_start;
  logic          d_mdu_div;
  logic          d_mdu_use;
  logic          stall;
  logic          mdu_busy;
  logic [CW-1:0] stall_count;

  modport master (
    output d_valid, d_use_rs, d_use_rt, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_mdu_start, d_mdu_div, d_mdu_use,
    input  stall, mdu_busy, stall_count
  );

  modport slave (
    input  d_valid, d_use_rs, d_use_rt, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_mdu_start, d_mdu_div, d_mdu_use,
    output stall, mdu_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register cycles-until-forwardable scoreboard with MDU busy timer and
// saturating stall counter; stall is combinational from state and D fields.
module hazard_scoreboard #(
  parameter int NREG        = 32,
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MW          = 4,
  parameter int CW          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   d
);

  logic [TW-1:0] pend [NREG];
  logic [MW-1:0] mdu_t;
  logic [CW-1:0] stall_cnt;
  logic          haz_rs;
  logic          haz_rt;
  logic          haz_mdu;
  logic          stall_i;
  logic          issue;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic [TW-1:0] dec_pend(input logic [TW-1:0] v);
    return (v != '0) ? v - TW'(1) : v;
  endfunction

  function automatic logic [MW-1:0] dec_timer(input logic [MW-1:0] v);
    return (v != '0) ? v - MW'(1) : v;
  endfunction

  always_comb begin
    haz_rs  = d.d_valid & d.d_use_rs & (d.d_rs != '0) & (pend[d.d_rs] > d.d_tuse_rs);
    haz_rt  = d.d_valid & d.d_use_rt & (d.d_rt != '0) & (pend[d.d_rt] > d.d_tuse_rt);
    haz_mdu = d.d_valid & d.d_mdu_use & (mdu_t != '0);
    stall_i = haz_rs | haz_rt | haz_mdu;
    issue   = d.d_valid & ~stall_i;
  end

  assign d.stall       = stall_i;
  assign d.mdu_busy    = (mdu_t != '0);
  assign d.stall_count = stall_cnt;

  // Entries keep counting down while D is frozen: E/M/W still advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      mdu_t     <= '0;
      stall_cnt <= '0;
    end else begin
      pend[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (issue && (d.d_a3 == AW'(r))) pend[r] <= d.d_tnew;
        else                             pend[r] <= dec_pend(pend[r]);
      end

      if (issue && d.d_mdu_start)
        mdu_t <= d.d_mdu_div ? MW'(DIV_CYCLES) : MW'(MULT_CYCLES);
      else
        mdu_t <= dec_timer(mdu_t);

      if (stall_i) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + random bench for hazard_scoreboard; the reference tracks the
// absolute cycle at which each register / the MDU becomes free.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int TW   = 2;
  localparam int CW   = 32;
  localparam int MULT_L = 5;
  localparam int DIV_L  = 10;

  logic clk;
  logic reset;

  hazard_scoreboard_if #(.AW(AW), .TW(TW), .CW(CW)) hif ();

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .TW(TW), .MULT_CYCLES(MULT_L),
    .DIV_CYCLES(DIV_L), .MW(4), .CW(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .d     (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: cycle at which each register's result is fully forwardable
  // from any stage, and the cycle at which the MDU becomes free.
  int cyc = 0;
  int ready_at [NREG];
  int mdu_free_at = 0;
  longint exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int cycles_left(input int r);
    int left;
    if (r == 0) return 0;
    left = ready_at[r] - cyc;
    return (left > 0) ? left : 0;
  endfunction

  function automatic logic model_stall();
    logic s;
    s = 1'b0;
    if (hif.d_valid) begin
      if (hif.d_use_rs && cycles_left(int'(hif.d_rs)) > int'(hif.d_tuse_rs)) s = 1'b1;
      if (hif.d_use_rt && cycles_left(int'(hif.d_rt)) > int'(hif.d_tuse_rt)) s = 1'b1;
      if (hif.d_mdu_use && (mdu_free_at > cyc)) s = 1'b1;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    mdu_free_at = 0;
    exp_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic urs, input logic urt,
                       input int rs, input int rt, input int trs, input int trt,
                       input int a3, input int tnew,
                       input logic mstart, input logic mdiv, input logic muse);
    hif.d_valid     = v;
    hif.d_use_rs    = urs;
    hif.d_use_rt    = urt;
    hif.d_rs        = AW'(rs);
    hif.d_rt        = AW'(rt);
    hif.d_tuse_rs   = TW'(trs);
    hif.d_tuse_rt   = TW'(trt);
    hif.d_a3        = AW'(a3);
    hif.d_tnew      = TW'(tnew);
    hif.d_mdu_start = mstart;
    hif.d_mdu_div   = mdiv;
    hif.d_mdu_use   = muse;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check outputs mid-cycle, then advance DUT and reference by one clock.
  task automatic cycle(output logic stalled);
    logic es;
    @(negedge clk);
    es = model_stall();
    chk("stall", {31'd0, hif.stall}, {31'd0, es});
    chk("mdu_busy", {31'd0, hif.mdu_busy}, {31'd0, (mdu_free_at > cyc)});
    chk("stall_count", hif.stall_count, exp_cnt[31:0]);
    stalled = hif.stall;
    @(posedge clk);
    if (es && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
    if (hif.d_valid && !es) begin
      if (hif.d_a3 != '0) ready_at[hif.d_a3] = cyc + 1 + int'(hif.d_tnew);
      if (hif.d_mdu_start) mdu_free_at = cyc + 1 + (hif.d_mdu_div ? DIV_L : MULT_L);
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic st;
    int   n_st;
    logic [CW-1:0] base;

    reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, hif.stall}, 32'd0);
    chk("reset_busy", {31'd0, hif.mdu_busy}, 32'd0);
    chk("reset_count", hif.stall_count, 32'd0);
    reset = 1'b1;

    // lw $8 (tnew 2) then addu rs=$8 tuse 1: one stall cycle
    base = hif.stall_count;
    drive(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0); cycle(st);
    drive(1, 1, 0, 8, 0, 1, 0, 10, 1, 0, 0, 0); cycle(st);
    chk("lw_addu_stall_c1", {31'd0, st}, 32'd1);
    cycle(st);
    chk("lw_addu_stall_c2", {31'd0, st}, 32'd0);
    idle(); repeat (3) cycle(st);
    chk("lw_addu_count", hif.stall_count - base, 32'd1);

    // lw $8 then beq rs=$8 tuse 0: two stall cycles
    base = hif.stall_count;
    drive(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0); cycle(st);
    drive(1, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    n_st = 0;
    for (int i = 0; i < 8; i++) begin cycle(st); if (!st) break; n_st++; end
    chk("lw_beq_stalls", n_st, 32'd2);
    idle(); repeat (3) cycle(st);
    chk("lw_beq_count", hif.stall_count - base, 32'd2);

    // addu $9 then sw rt=$9 tuse 2: no stall; addu $9 then beq rs=$9: one stall
    drive(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0); cycle(st);
    drive(1, 0, 1, 0, 9, 0, 2, 0, 0, 0, 0, 0); cycle(st);
    chk("addu_sw_nostall", {31'd0, st}, 32'd0);
    idle(); repeat (2) cycle(st);
    drive(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0); cycle(st);
    drive(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    n_st = 0;
    for (int i = 0; i < 8; i++) begin cycle(st); if (!st) break; n_st++; end
    chk("addu_beq_stalls", n_st, 32'd1);
    idle(); repeat (2) cycle(st);

    // div then mflo: 10 stall cycles; mult then mflo: 5
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); cycle(st);
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    n_st = 0;
    for (int i = 0; i < 20; i++) begin cycle(st); if (!st) break; n_st++; end
    chk("div_mflo_stalls", n_st, DIV_L);
    chk("div_busy_after", {31'd0, hif.mdu_busy}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); cycle(st);
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    n_st = 0;
    for (int i = 0; i < 20; i++) begin cycle(st); if (!st) break; n_st++; end
    chk("mult_mflo_stalls", n_st, MULT_L);
    idle(); cycle(st);

    // Writes to $0 are never tracked; bubbles never stall
    drive(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); cycle(st);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(st);
    chk("zero_reg_nostall", {31'd0, st}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0); cycle(st);
    drive(0, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0); cycle(st);
    chk("bubble_nostall", {31'd0, st}, 32'd0);
    idle(); repeat (3) cycle(st);

    // Reset mid-div with mflo waiting: stall and busy drop immediately
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); cycle(st);
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1); cycle(st); cycle(st);
    reset = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, hif.mdu_busy}, 32'd0);
    chk("midreset_stall", {31'd0, hif.stall}, 32'd0);
    chk("midreset_count", hif.stall_count, 32'd0);
    model_reset();
    #1 reset = 1'b1;
    idle(); cycle(st);

    // Random traffic on a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      logic ms;
      ms = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            ms, $urandom_range(0, 1), ms | ($urandom_range(0, 5) == 0));
      cycle(st);
    end
    idle(); repeat (12) cycle(st);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational D-stage stall logic.
- Replaces per-stage A3/Tnew comparisons with a per-register "cycles-until-forwardable" scoreboard that counts down every cycle.
- Adds a stateful MDU busy timer (separate mult/div latencies) and a saturating stall performance counter.
- Sits beside the D stage. Its `stall` output freezes PC/IF-ID and bubbles ID-EX.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is never tracked.
- AW, 5, register address width (clog2 NREG).
- TW, 2, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, MDU busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, MDU busy cycles after a div/divu issue.
- MW, 4, MDU timer width; must hold max(MULT_CYCLES, DIV_CYCLES).
- CW, 32, stall performance counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  D holds a real instruction; 0 means bubble.
- d_use_rs  in  1  D instruction reads rs.
- d_use_rt  in  1  D instruction reads rt.
- d_rs  in  AW  rs address (A1).
- d_rt  in  AW  rt address (A2).
- d_tuse_rs  in  TW  Tuse of rs.
- d_tuse_rt  in  TW  Tuse of rt.
- d_a3  in  AW  destination register; 0 means no write.
- d_tnew  in  TW  Tnew the instruction will have while in E (ALU = 1, load = 2, link = 0).
- d_mdu_start  in  1  D is mult/multu/div/divu.
- d_mdu_div  in  1  with d_mdu_start: 1 = divide, 0 = multiply.
- d_mdu_use  in  1  D is mfhi/mflo/mthi/mtlo or an MDU start.
- stall  out  1  combinational stall request.
- mdu_busy  out  1  MDU timer nonzero (registered state).
- stall_count  out  CW  number of stalled cycles since reset.

Behaviour:
- State:
  - `pend[r]` (TW bits) for r = 1..NREG-1.
  - `mdu_t` (MW bits).
  - `stall_count` (CW bits).
- Reset (asynchronous, `reset` = 0): all `pend` = 0, `mdu_t` = 0, `stall_count` = 0, hence `stall` = 0 and `mdu_busy` = 0.
- Data hazard, for rs: `haz_rs` = d_valid & d_use_rs & (d_rs != 0) & (pend[d_rs] > d_tuse_rs). Unsigned compare.
- `haz_rt` is the same with rt fields.
- MDU hazard: `haz_mdu` = d_valid & d_mdu_use & (mdu_t != 0).
- `stall` = haz_rs | haz_rt | haz_mdu. It is purely combinational from state and D inputs, with no flop on the output.
- `issue` = d_valid & !stall.
- Per-cycle scoreboard update:
  - For every r: if issue & (d_a3 == r) & (r != 0), then pend[r] <= d_tnew.
  - Otherwise, if pend[r] != 0, pend[r] <= pend[r] - 1.
  - Otherwise pend[r] holds at 0.
  - Decrement is unconditional on stall: E/M/W keep advancing while D is frozen and a bubble enters E.
- Consequences (load, d_tnew = 2):
  - Cycle after issue (load in E): pend = 2, so a Tuse-0 or Tuse-1 consumer stalls.
  - Next cycle (M): pend = 1, Tuse-1 proceeds.
  - Next cycle (W): pend = 0, everything proceeds via forwarding.
- Issue to a register whose entry is still counting overwrites it; the newer writer wins, matching forwarding priority.
- A d_a3 write with d_tnew = 0 clears the entry immediately.
- MDU timer:
  - On issue & d_mdu_start: mdu_t <= DIV_CYCLES if d_mdu_div, else MULT_CYCLES.
  - Else if mdu_t != 0: mdu_t <= mdu_t - 1.
  - `mdu_busy` = (mdu_t != 0).
  - A start arriving while busy stalls, because start implies d_mdu_use.
- Perf counter: stall_count increments each cycle `stall` = 1 and saturates at all-ones; it is never cleared except by reset.
- d_valid = 0 suppresses every hazard term and any issue; scoreboard and timer still count down.
- Reset mid-stall drops `stall` asynchronously in the same cycle.

Test Plan:
- Reset with all inputs at 0, then release → stall = 0, mdu_busy = 0, stall_count = 0.
- Cycle 0: issue lw (d_a3 = 8, d_tnew = 2). Cycle 1: addu with rs = 8, tuse = 1 → stall = 1 in cycle 1, stall = 0 in cycle 2, stall_count = 1.
- Issue lw to $8, then beq with rs = 8, tuse = 0 → stall for exactly 2 cycles, stall_count = 2.
- Issue addu to $9 (tnew = 1), then sw with rt = 9, tuse_rt = 2 → no stall. Same producer followed by beq with rs = 9 → 1 stall cycle.
- Issue div (d_mdu_div = 1), then mflo the next cycle → stall for 10 cycles, mdu_busy falls on cycle 11, mflo issues that cycle. Repeat with mult → 5 stall cycles.
- Issue lw to $0 then a consumer of $0, or hold d_valid = 0 with a conflicting rs → stall = 0 in both cases. Assert reset mid-div → mdu_busy = 0 immediately.
